// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word requests to instruction memory, buffers returned
// words with their PCs, and hands them to decode; redirects flush and squash in-flight words.
module fetch_unit #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = CW + 1;

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         discard_q, discard_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] fifo_pc_q   [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_word_q [DEPTH];

    logic [DATA_WIDTH-1:0] redirect_tgt;
    logic [SW-1:0]         credit_used;
    logic                  req_fire;
    logic                  push;
    logic                  drop;
    logic                  pop;
    logic                  rsp_squash;

    // Buffered plus in-flight words may never exceed the FIFO depth, so a push never overflows.
    assign credit_used    = SW'(count_q) + SW'(outst_q);
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < SW'(DEPTH));
    assign imem_addr      = pc_q;
    assign instr_valid    = (count_q != '0) && !redirect_valid;
    assign instr          = fifo_word_q[rd_ptr_q];
    assign instr_pc       = fifo_pc_q[rd_ptr_q];

    assign redirect_tgt = redirect_pc & ~DATA_WIDTH'(3);
    assign req_fire     = imem_req_valid && imem_req_ready;
    assign drop         = imem_rsp_valid && (discard_q != '0);
    assign push         = imem_rsp_valid && (discard_q == '0) && (outst_q != '0) && !redirect_valid;
    assign pop          = instr_valid && instr_ready;
    // A response arriving with a redirect is only counted if it belongs to a tracked request.
    assign rsp_squash   = imem_rsp_valid && ((discard_q != '0) || (outst_q != '0));

    always_comb begin
        pc_d      = pc_q;
        rsp_pc_d  = rsp_pc_q;
        count_d   = count_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;

        if (redirect_valid) begin
            pc_d      = redirect_tgt;
            rsp_pc_d  = redirect_tgt;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            outst_d   = '0;
            discard_d = discard_q + outst_q - CW'(rsp_squash);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + DATA_WIDTH'(4);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + DATA_WIDTH'(4);
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            outst_d   = outst_q + CW'(req_fire) - CW'(push);
            discard_d = discard_q - CW'(drop);
            count_d   = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            rsp_pc_q  <= RESET_PC;
            count_q   <= '0;
            outst_q   <= '0;
            discard_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            rsp_pc_q  <= rsp_pc_d;
            count_q   <= count_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
            fifo_word_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule
